// File: rtl/toggle_event_rx.sv
// toggle_event_rx
//   Receive end of a toggle-encoded event link. The remote sender flips a
//   T flip-flop once per event; this block synchronises that level into clk,
//   turns each level change into one event, queues events as a pending count
//   drained over a valid/ready handshake, and keeps a wrapping running total
//   plus a sticky overflow flag.
//
//   A short PRIME phase after reset lets the synchroniser fill with the
//   current remote level, so a level that is already 1 when reset is released
//   is not mistaken for an event.

module toggle_event_rx #(
   parameter int SYNC_STAGES = 2,   // flops in the tgl_in synchroniser (>= 2)
   parameter int CW          = 4,   // pend_cnt width, max pending = 2**CW-1
   parameter int TW          = 8    // total_cnt width, wraps modulo 2**TW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tgl_in,
   input  logic          evt_ready,
   input  logic          clr_ovf,
   output logic          evt_valid,
   output logic [CW-1:0] pend_cnt,
   output logic [TW-1:0] total_cnt,
   output logic          overflow,
   output logic          busy_prime
);

   // Prime counter counts 0..SYNC_STAGES, so it needs enough bits for that.
   localparam int PW = $clog2(SYNC_STAGES + 1);

   typedef enum logic {
      PRIME = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t                 state;
   logic [PW-1:0]          prime_cnt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   logic sl;       // synchronised toggle level
   logic chg;      // synchronised level differs from last cycle
   logic evt;      // a level change that counts as an event
   logic accept;   // consumer takes one pending event this edge
   logic full;     // pend_cnt at its maximum
   logic drop;     // event lost because the pending queue is full

   assign sl        = sync[SYNC_STAGES-1];
   assign chg       = sl ^ prev;
   assign evt_valid = (pend_cnt != '0);
   assign accept    = evt_valid & evt_ready;
   assign full      = &pend_cnt;

   // Classify this cycle's event: only RUN sees events, and an event into a
   // full queue is dropped unless an accept frees a slot on the same edge.
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      evt  = 1'b0;
      drop = 1'b0;
      if (state == RUN) begin
         evt = chg;
      end
      if (evt && full && !accept) begin
         drop = 1'b1;
      end
   end

   // Synchroniser chain and previous-level register; prev tracks sl in every
   // state so the first RUN cycle compares against a settled level.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values and the chain shifts by exactly one stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], tgl_in};
         prev <= sl;
      end
   end

   // PRIME/RUN sequencer: PRIME lasts SYNC_STAGES+1 cycles after reset
   // deasserts, then RUN until the next reset. busy_prime is registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= PRIME;
         prime_cnt  <= '0;
         busy_prime <= 1'b1;
      end else begin
         case (state)
            PRIME: begin
               if (prime_cnt == PW'(SYNC_STAGES)) begin
                  state      <= RUN;
                  busy_prime <= 1'b0;
               end else begin
                  prime_cnt  <= prime_cnt + PW'(1);
                  busy_prime <= 1'b1;
               end
            end
            RUN: begin
               state      <= RUN;
               busy_prime <= 1'b0;
            end
            default: begin
               state      <= PRIME;
               prime_cnt  <= '0;
               busy_prime <= 1'b1;
            end
         endcase
      end
   end

   // Pending count, running total and sticky overflow. An event and an accept
   // on the same edge cancel in pend_cnt but the event still adds to the total.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_cnt  <= '0;
         total_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         if (evt && !accept && !full) begin
            pend_cnt <= pend_cnt + CW'(1);
         end else if (accept && !evt) begin
            pend_cnt <= pend_cnt - CW'(1);
         end

         if (evt && !drop) begin
            total_cnt <= total_cnt + TW'(1);
         end

         // A fresh drop outranks a clear arriving on the same edge.
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Bench for toggle_event_rx: directed stimulus pushes expected output
// snapshots into a queue; a monitor pops and compares them on the falling
// edge following each push, against the outputs settled after the rising edge.

module tb_toggle_event_rx;

   localparam int SYNC_STAGES = 2;
   localparam int CW          = 4;
   localparam int TW          = 8;

   logic          clk;
   logic          reset;
   logic          tgl_in;
   logic          evt_ready;
   logic          clr_ovf;
   logic          evt_valid;
   logic [CW-1:0] pend_cnt;
   logic [TW-1:0] total_cnt;
   logic          overflow;
   logic          busy_prime;

   typedef struct {
      string name;
      int    pend;
      int    total;
      int    ovf;
      int    valid;
      int    busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   toggle_event_rx #(
      .SYNC_STAGES (SYNC_STAGES),
      .CW          (CW),
      .TW          (TW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tgl_in     (tgl_in),
      .evt_ready  (evt_ready),
      .clr_ovf    (clr_ovf),
      .evt_valid  (evt_valid),
      .pend_cnt   (pend_cnt),
      .total_cnt  (total_cnt),
      .overflow   (overflow),
      .busy_prime (busy_prime)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: compare every queued expectation on the next falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, ".pend_cnt"},   int'(pend_cnt),   e.pend);
            check({e.name, ".total_cnt"},  int'(total_cnt),  e.total);
            check({e.name, ".overflow"},   int'(overflow),   e.ovf);
            check({e.name, ".evt_valid"},  int'(evt_valid),  e.valid);
            check({e.name, ".busy_prime"}, int'(busy_prime), e.busy);
         end
      end
   end

   // Advance n rising edges, leaving time just after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input int pend, input int total,
                             input int ovf, input int valid, input int busy);
      exp_t e;
      e.name  = name;
      e.pend  = pend;
      e.total = total;
      e.ovf   = ovf;
      e.valid = valid;
      e.busy  = busy;
      exp_q.push_back(e);
   endtask

   // One event: flip the remote level, then respect the minimum spacing.
   task automatic toggle_wait();
      tgl_in = ~tgl_in;
      step(4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int drain_wait;
      reset     = 1'b1;
      tgl_in    = 1'b1;
      evt_ready = 1'b0;
      clr_ovf   = 1'b0;

      // Test 1: reset with tgl_in already high, then PRIME, then idle RUN.
      step(2);
      expect_out("reset", 0, 0, 0, 0, 1);
      reset = 1'b0;
      step(1);
      expect_out("prime1", 0, 0, 0, 0, 1);
      step(2);
      expect_out("run_idle", 0, 0, 0, 0, 0);
      step(2);
      expect_out("run_idle2", 0, 0, 0, 0, 0);

      // Test 2: three toggles with evt_ready low; first evt_valid two edges on.
      tgl_in = ~tgl_in;
      step(1);
      expect_out("lat_edge1", 0, 0, 0, 0, 0);
      step(1);
      expect_out("lat_edge2pre", 0, 0, 0, 0, 0);
      step(1);
      expect_out("lat_first", 1, 1, 0, 1, 0);
      step(1);
      toggle_wait();
      toggle_wait();
      expect_out("three_evt", 3, 3, 0, 1, 0);

      // Test 3: drain three events in three cycles; ready ignored when empty.
      evt_ready = 1'b1;
      step(1);
      expect_out("drain1", 2, 3, 0, 1, 0);
      step(1);
      expect_out("drain2", 1, 3, 0, 1, 0);
      step(1);
      expect_out("drain3", 0, 3, 0, 0, 0);
      step(1);
      expect_out("drain_empty", 0, 3, 0, 0, 0);
      evt_ready = 1'b0;

      // Test 4: fill to 15, the 16th event overflows, clear it.
      for (int i = 0; i < 15; i++) toggle_wait();
      expect_out("full15", 15, 18, 0, 1, 0);
      toggle_wait();
      expect_out("ovf_drop", 15, 18, 1, 1, 0);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      expect_out("ovf_clr", 15, 18, 0, 1, 0);
      // Another drop on the same edge as clr_ovf: overflow stays set.
      tgl_in = ~tgl_in;
      step(2);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      expect_out("ovf_wins", 15, 18, 1, 1, 0);
      clr_ovf = 1'b1;
      step(1);
      clr_ovf = 1'b0;
      expect_out("ovf_clr2", 15, 18, 0, 1, 0);
      step(2);

      // Test 5: drain to 2, then event and accept on the same edge.
      evt_ready = 1'b1;
      step(13);
      evt_ready = 1'b0;
      expect_out("drain_to2", 2, 18, 0, 1, 0);
      tgl_in = ~tgl_in;
      step(2);
      evt_ready = 1'b1;
      step(1);
      evt_ready = 1'b0;
      expect_out("evt_and_acc", 2, 19, 0, 1, 0);
      step(2);

      // Test 6: build pend to 5, reset for one cycle, PRIME, then one event.
      toggle_wait();
      toggle_wait();
      toggle_wait();
      expect_out("pend5", 5, 22, 0, 1, 0);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      expect_out("mid_reset", 0, 0, 0, 0, 1);
      step(1);
      expect_out("mid_prime2", 0, 0, 0, 0, 1);
      step(1);
      expect_out("mid_prime3", 0, 0, 0, 0, 1);
      step(1);
      expect_out("mid_run", 0, 0, 0, 0, 0);
      tgl_in = ~tgl_in;
      step(3);
      expect_out("after_reset_evt", 1, 1, 0, 1, 0);
      step(1);

      // total_cnt wraps: 254 more events reach 255, one more wraps to 0.
      evt_ready = 1'b1;
      for (int i = 0; i < 254; i++) toggle_wait();
      expect_out("total255", 0, 255, 0, 0, 0);
      toggle_wait();
      expect_out("total_wrap", 0, 0, 0, 0, 0);
      evt_ready = 1'b0;

      // Let the monitor consume every pending expectation, bounded.
      drain_wait = 0;
      while (exp_q.size() > 0 && drain_wait < 100) begin
         step(1);
         drain_wait++;
      end
      check("queue_drained", exp_q.size(), 0);
      step(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
